// File: rtl/alarm_sequencer.sv
// Alarm ringing sequencer: matches current time against the alarm time and walks
// IDLE -> RINGING -> SNOOZE/DONE with a 1 s prescaled timer for timeout and snooze.
module alarm_sequencer #(
    parameter int CLK_HZ         = 50000000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_enable,
    input  logic [4:0] cur_hh,
    input  logic [5:0] cur_mm,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       blink_signal,
    output logic       buzzer_en,
    output logic       snoozing,
    output logic [3:0] snooze_count,
    output logic [1:0] alarm_state
);

    localparam int PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SEC_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_SAT  = SEC_W'(SEC_MAX);
    localparam logic [SEC_W-1:0] RING_END = SEC_W'(RING_TIMEOUT_S - 1);
    localparam logic [SEC_W-1:0] SNZ_END  = SEC_W'(SNOOZE_S - 1);
    localparam logic [3:0]       SNZ_LIM  = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [PRE_W-1:0] prescaler;
    logic [SEC_W-1:0] sec_cnt;
    logic [3:0]       snooze_count_n;
    logic             match, sec_tick;

    assign match    = alarm_enable && (cur_hh == alarm_hh) && (cur_mm == alarm_mm);
    assign sec_tick = (prescaler == PRE_TC);

    always_comb begin
        state_n        = state;
        snooze_count_n = snooze_count;
        case (state)
            IDLE: begin
                if (match) begin
                    state_n        = RINGING;
                    snooze_count_n = 4'd0;
                end
            end
            RINGING: begin
                if (!alarm_enable) begin
                    state_n        = IDLE;
                    snooze_count_n = 4'd0;
                end else if (stop_btn) begin
                    state_n = DONE;
                end else if (snooze_btn && (snooze_count < SNZ_LIM)) begin
                    state_n        = SNOOZE;
                    snooze_count_n = snooze_count + 4'd1;
                end else if (sec_tick && (sec_cnt == RING_END)) begin
                    state_n = DONE;
                end
            end
            SNOOZE: begin
                if (!alarm_enable) begin
                    state_n        = IDLE;
                    snooze_count_n = 4'd0;
                end else if (stop_btn) begin
                    state_n = DONE;
                end else if (sec_tick && (sec_cnt == SNZ_END)) begin
                    state_n = RINGING;
                end
            end
            DONE: begin
                // Hold until the matching minute is over so we don't re-trigger.
                if (!match) begin
                    state_n        = IDLE;
                    snooze_count_n = 4'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prescaler    <= '0;
            sec_cnt      <= '0;
            snooze_count <= 4'd0;
            blink_signal <= 1'b0;
            buzzer_en    <= 1'b0;
            snoozing     <= 1'b0;
            alarm_state  <= 2'd0;
        end else begin
            state        <= state_n;
            snooze_count <= snooze_count_n;
            // Every state entry restarts the timer so the first second is full length.
            if (state_n != state) begin
                prescaler <= '0;
                sec_cnt   <= '0;
            end else begin
                prescaler <= sec_tick ? '0 : prescaler + 1'b1;
                if (sec_tick && (sec_cnt != SEC_SAT))
                    sec_cnt <= sec_cnt + 1'b1;
            end
            blink_signal <= (state_n == RINGING);
            buzzer_en    <= (state_n == RINGING);
            snoozing     <= (state_n == SNOOZE);
            alarm_state  <= state_n;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a 4-cycle second, 3 s ring, 2 s snooze, 2 snoozes.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_enable;
    logic [4:0] cur_hh, alarm_hh;
    logic [5:0] cur_mm, alarm_mm;
    logic       snooze_btn, stop_btn;
    logic       blink_signal, buzzer_en, snoozing;
    logic [3:0] snooze_count;
    logic [1:0] alarm_state;

    integer checks = 0;
    integer errors = 0;

    alarm_sequencer #(
        .CLK_HZ(4), .RING_TIMEOUT_S(3), .SNOOZE_S(2), .MAX_SNOOZE(2)
    ) dut (
        .clk(clk), .reset(reset), .alarm_enable(alarm_enable),
        .cur_hh(cur_hh), .cur_mm(cur_mm), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .blink_signal(blink_signal), .buzzer_en(buzzer_en), .snoozing(snoozing),
        .snooze_count(snooze_count), .alarm_state(alarm_state)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs set before the call are sampled on it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        alarm_enable = 1'b0; cur_mm = 6'd0; snooze_btn = 1'b0; stop_btn = 1'b0;
        reset = 1'b1; step(); reset = 1'b0; step();
    endtask

    task automatic trigger(input string tag);
        cur_hh = 5'd7; cur_mm = 6'd30; alarm_hh = 5'd7; alarm_mm = 6'd30; alarm_enable = 1'b1;
        step();
        checks++;
        if (alarm_state !== 2'd1 || blink_signal !== 1'b1) begin
            errors++;
            $display("FAIL %s_trigger: state=%0d blink=%0b expected state=1 blink=1", tag, alarm_state, blink_signal);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; alarm_enable = 1'b1; snooze_btn = 1'b0; stop_btn = 1'b0;
        cur_hh = 5'd7; cur_mm = 6'd30; alarm_hh = 5'd7; alarm_mm = 6'd30;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({alarm_state, blink_signal, buzzer_en, snoozing, snooze_count} !== 9'd0) begin
                errors++;
                $display("FAIL reset_outputs: state=%0d blink=%0b buz=%0b snz=%0b cnt=%0d expected all 0",
                         alarm_state, blink_signal, buzzer_en, snoozing, snooze_count);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (alarm_state !== 2'd1 || blink_signal !== 1'b1 || buzzer_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ring: state=%0d blink=%0b buz=%0b expected 1 1 1",
                     alarm_state, blink_signal, buzzer_en);
        end
    endtask

    task automatic test_timeout();
        int ring_cycles;
        go_idle();
        trigger("timeout");
        ring_cycles = 1;
        for (int i = 0; i < 20 && alarm_state == 2'd1; i++) begin
            step();
            if (alarm_state == 2'd1) ring_cycles++;
        end
        checks++;
        if (ring_cycles != 12 || alarm_state !== 2'd3 || blink_signal !== 1'b0) begin
            errors++;
            $display("FAIL timeout_len: ring_cycles=%0d state=%0d blink=%0b expected 12 3 0",
                     ring_cycles, alarm_state, blink_signal);
        end
        cur_mm = 6'd31;
        step();
        checks++;
        if (alarm_state !== 2'd0) begin
            errors++;
            $display("FAIL timeout_idle: state=%0d expected 0", alarm_state);
        end
    endtask

    task automatic test_snooze_limit();
        go_idle();
        trigger("snz");
        for (int n = 1; n <= 2; n++) begin
            snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
            checks++;
            if (alarm_state !== 2'd2 || snoozing !== 1'b1 || blink_signal !== 1'b0 || snooze_count !== 4'(n)) begin
                errors++;
                $display("FAIL snooze_enter%0d: state=%0d snz=%0b blink=%0b cnt=%0d expected 2 1 0 %0d",
                         n, alarm_state, snoozing, blink_signal, snooze_count, n);
            end
            for (int i = 0; i < 7; i++) step();
            checks++;
            if (alarm_state !== 2'd2) begin
                errors++;
                $display("FAIL snooze_hold%0d: state=%0d expected 2", n, alarm_state);
            end
            step();
            checks++;
            if (alarm_state !== 2'd1 || snoozing !== 1'b0 || buzzer_en !== 1'b1) begin
                errors++;
                $display("FAIL snooze_rering%0d: state=%0d snz=%0b buz=%0b expected 1 0 1",
                         n, alarm_state, snoozing, buzzer_en);
            end
        end
        // Limit reached: this pulse is dropped and the ring timer keeps running.
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        checks++;
        if (alarm_state !== 2'd1 || snooze_count !== 4'd2) begin
            errors++;
            $display("FAIL snooze_ignored: state=%0d cnt=%0d expected 1 2", alarm_state, snooze_count);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (alarm_state !== 2'd1) begin
            errors++;
            $display("FAIL snooze_last_ring: state=%0d expected 1", alarm_state);
        end
        step();
        checks++;
        if (alarm_state !== 2'd3 || snooze_count !== 4'd2) begin
            errors++;
            $display("FAIL snooze_done: state=%0d cnt=%0d expected 3 2", alarm_state, snooze_count);
        end
        cur_mm = 6'd31;
        step();
        checks++;
        if (alarm_state !== 2'd0 || snooze_count !== 4'd0) begin
            errors++;
            $display("FAIL snooze_clear: state=%0d cnt=%0d expected 0 0", alarm_state, snooze_count);
        end
    endtask

    task automatic test_simultaneous();
        go_idle();
        trigger("simul");
        step(); step();
        stop_btn = 1'b1; snooze_btn = 1'b1; step(); stop_btn = 1'b0; snooze_btn = 1'b0;
        checks++;
        if (alarm_state !== 2'd3 || snooze_count !== 4'd0 || snoozing !== 1'b0) begin
            errors++;
            $display("FAIL simul_stop_wins: state=%0d cnt=%0d snz=%0b expected 3 0 0",
                     alarm_state, snooze_count, snoozing);
        end
    endtask

    task automatic test_cancel_reset();
        go_idle();
        trigger("cancel");
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        step();
        alarm_enable = 1'b0; step();
        checks++;
        if (alarm_state !== 2'd0 || snooze_count !== 4'd0 || snoozing !== 1'b0) begin
            errors++;
            $display("FAIL cancel_snooze: state=%0d cnt=%0d snz=%0b expected 0 0 0",
                     alarm_state, snooze_count, snoozing);
        end
        trigger("rerun");
        step();
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if ({alarm_state, blink_signal, buzzer_en, snoozing, snooze_count} !== 9'd0) begin
            errors++;
            $display("FAIL midring_reset: state=%0d blink=%0b buz=%0b expected all 0",
                     alarm_state, blink_signal, buzzer_en);
        end
        step();
        checks++;
        if (alarm_state !== 2'd1 || blink_signal !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ring: state=%0d blink=%0b expected 1 1", alarm_state, blink_signal);
        end
    endtask

    task automatic test_done_hold();
        int bad;
        go_idle();
        trigger("hold");
        stop_btn = 1'b1; step(); stop_btn = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (alarm_state !== 2'd3 || blink_signal !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL done_hold: %0d cycles left DONE or rang, expected 0 (last state=%0d)", bad, alarm_state);
        end
        cur_mm = 6'd31; step();
        checks++;
        if (alarm_state !== 2'd0) begin
            errors++;
            $display("FAIL done_release: state=%0d expected 0", alarm_state);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_snooze_limit();
        test_simultaneous();
        test_cancel_reset();
        test_done_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
